serial_sub_nbit: RTL

//  Multi-cycle N-bit subtractor computing diff = x - y - bin, built from a chain of
//  1-bit full-subtractor slices. It processes BPC bits per clock, LSB slice first,
//  and carries the borrow between cycles in a register.

---
 rtl/serial_sub_nbit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_sub_nbit.sv
// Multi-cycle N-bit subtractor: diff = x - y - bin, BPC bits per clock, LSB first.
// Start/busy/done handshake; diff/bout/ovf are held until the next completion.
module serial_sub_nbit #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NS = WIDTH / BPC;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  generate
    if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_param_check
      $error("serial_sub_nbit: illegal WIDTH/BPC combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic [BPC-1:0]   d_s;
  logic             chain_bout;
  logic             chain_bmsb;
  logic             b;

  // Handshake: start is a request honoured only in IDLE or DONE; busy marks the
  // RUN cycles, done is a one-cycle pulse in DONE when diff/bout/ovf are fresh.
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign last = (cnt == CW'(NS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN:  if (last) state_next = DONE;
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // BPC chained full-subtractor slices; chain_bmsb is the borrow entering the top slice.
  always_comb begin
    d_s        = '0;
    chain_bmsb = 1'b0;
    b          = brw;
    for (int i = 0; i < BPC; i++) begin
      if (i == BPC - 1) chain_bmsb = b;
      d_s[i] = x_sh[i] ^ y_sh[i] ^ b;
      b      = (~x_sh[i] & y_sh[i]) | (~(x_sh[i] ^ y_sh[i]) & b);
    end
    chain_bout = b;
  end

  assign acc_next = (acc >> BPC) | (WIDTH'(d_s) << (WIDTH - BPC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sh <= '0;
      y_sh <= '0;
      acc  <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      x_sh <= x;
      y_sh <= y;
      brw  <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      x_sh <= x_sh >> BPC;
      y_sh <= y_sh >> BPC;
      acc  <= acc_next;
      brw  <= chain_bout;
      cnt  <= cnt + CW'(1);
      if (last) begin
        diff <= acc_next;
        bout <= chain_bout;
        ovf  <= chain_bmsb ^ chain_bout;
      end
    end
  end

endmodule
